// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch (read-only) and the
// data stage (read/write, byte enable). Data wins ties until the streak limit is hit.
module mem_port_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  output logic              if_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic              d_byte_en,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              d_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic              mem_byte_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              bus_error
);

  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);
  localparam logic [TW-1:0] T_LAST     = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D} state_t;

  state_t            state, state_nxt;
  logic [SW-1:0]     streak;
  logic [TW-1:0]     tcnt;
  logic              if_elig, d_elig, grant_if, grant_d, done, abort;
  logic [DATA_W-1:0] result;

  // A request seen during its own valid pulse still belongs to the finished access.
  assign if_elig  = if_req & ~if_valid;
  assign d_elig   = d_req & ~d_valid;
  assign grant_d  = (state == IDLE) && d_elig && !(if_elig && streak == STREAK_MAX);
  assign grant_if = (state == IDLE) && if_elig && !grant_d;
  assign done     = (state != IDLE) && mem_ready;
  assign abort    = (state != IDLE) && !mem_ready && (tcnt == T_LAST);
  assign result   = abort ? '1 : (mem_we ? '0 : mem_rdata);

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_d)       state_nxt = BUSY_D;
        else if (grant_if) state_nxt = BUSY_IF;
      end
      default: if (done || abort) state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_req  = (state != IDLE);
    if_stall = if_req & ~if_valid;
    d_stall  = d_req & ~d_valid;
  end

  // Grant edge latches the winner; completion edge returns data and a one-cycle valid.
  always_ff @(posedge clock) begin
    if (!reset) begin
      streak      <= '0;
      tcnt        <= '0;
      mem_we      <= 1'b0;
      mem_byte_en <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      if_rdata    <= '0;
      if_valid    <= 1'b0;
      d_rdata     <= '0;
      d_valid     <= 1'b0;
      bus_error   <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
      if (grant_d || grant_if) begin
        mem_we      <= grant_d & d_we;
        mem_byte_en <= grant_d & d_byte_en;
        mem_addr    <= grant_d ? d_addr : if_addr;
        mem_wdata   <= grant_d ? d_wdata : '0;
        tcnt        <= '0;
      end
      if (state == IDLE) begin
        if (grant_d && if_req)
          streak <= (streak == STREAK_MAX) ? streak : streak + 1'b1;
        else if (grant_if || !if_req)
          streak <= '0;
      end
      if (done || abort) begin
        if (state == BUSY_IF) begin
          if_rdata <= result;
          if_valid <= 1'b1;
        end else begin
          d_rdata <= result;
          d_valid <= 1'b1;
        end
        if (abort) bus_error <= 1'b1;
      end else if (state != IDLE) begin
        tcnt <= tcnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: requesters, a random-latency memory with
// stuck windows, occasional resets, all checked each cycle against a transaction model.
module tb_mem_port_arbiter;

  localparam int MAXS = 4;
  localparam int TO   = 15;

  logic        clock = 1'b0;
  logic        reset;
  logic        if_req, d_req, d_we, d_byte_en, mem_ready;
  logic [15:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [15:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic        if_valid, if_stall, d_valid, d_stall;
  logic        mem_req, mem_we, mem_byte_en, bus_error;

  always #5 clock = ~clock;

  mem_port_arbiter dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_valid(if_valid), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_byte_en(d_byte_en), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_valid(d_valid), .d_stall(d_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_byte_en(mem_byte_en),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .bus_error(bus_error)
  );

  // Reference model: the transaction in flight (owner 0 none, 1 fetch, 2 data) plus results.
  int          m_owner, m_wait, m_streak;
  logic        m_we, m_be;
  logic [15:0] m_addr, m_wdata;
  logic        e_ifv, e_dv, e_berr;
  logic [15:0] e_ifr, e_dr;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      if (n_bad <= 30)
        $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_update();
    bit          ie, de, fin;
    logic        nifv, ndv;
    logic [15:0] res;
    if (!reset) begin
      m_owner = 0; m_wait = 0; m_streak = 0;
      m_we = 0; m_be = 0; m_addr = 0; m_wdata = 0;
      e_ifv = 0; e_dv = 0; e_berr = 0; e_ifr = 0; e_dr = 0;
      return;
    end
    nifv = 0; ndv = 0; fin = 0; res = 0;
    if (m_owner == 0) begin
      ie = if_req && !e_ifv;
      de = d_req && !e_dv;
      if (de && !(ie && m_streak == MAXS)) begin
        m_owner = 2; m_we = d_we; m_be = d_byte_en; m_addr = d_addr; m_wdata = d_wdata;
        m_wait = 0;
        m_streak = if_req ? ((m_streak < MAXS) ? m_streak + 1 : MAXS) : 0;
      end else if (ie) begin
        m_owner = 1; m_we = 0; m_be = 0; m_addr = if_addr; m_wdata = 0;
        m_wait = 0; m_streak = 0;
      end else if (!if_req) begin
        m_streak = 0;
      end
    end else begin
      if (mem_ready) begin
        res = (m_owner == 2 && m_we) ? 16'h0000 : mem_rdata;
        fin = 1;
      end else begin
        m_wait++;
        if (m_wait == TO) begin
          res = 16'hFFFF; fin = 1; e_berr = 1;
        end
      end
      if (fin) begin
        if (m_owner == 1) begin e_ifr = res; nifv = 1; end
        else              begin e_dr = res;  ndv = 1;  end
        m_owner = 0;
      end
    end
    e_ifv = nifv;
    e_dv  = ndv;
  endtask

  task automatic compare_all();
    chk("mem_req",     mem_req,     m_owner != 0);
    chk("mem_we",      mem_we,      m_we);
    chk("mem_byte_en", mem_byte_en, m_be);
    chk("mem_addr",    mem_addr,    m_addr);
    chk("mem_wdata",   mem_wdata,   m_wdata);
    chk("if_valid",    if_valid,    e_ifv);
    chk("if_rdata",    if_rdata,    e_ifr);
    chk("d_valid",     d_valid,     e_dv);
    chk("d_rdata",     d_rdata,     e_dr);
    chk("bus_error",   bus_error,   e_berr);
    chk("if_stall",    if_stall,    if_req & ~e_ifv);
    chk("d_stall",     d_stall,     d_req & ~e_dv);
  endtask

  task automatic gen_inputs(input int cyc);
    bit stuck;
    reset = !(cyc < 2 || $urandom_range(0, 249) == 0);
    if (!reset) begin
      if_req = 0;
      d_req  = 0;
    end else begin
      // A pending request is held unchanged until its valid pulse.
      if (!(if_req && !e_ifv)) begin
        if_req  = ($urandom_range(0, 9) < 6);
        if_addr = 16'($urandom);
      end
      if (!(d_req && !e_dv)) begin
        d_req     = ($urandom_range(0, 9) < 6);
        d_we      = 1'($urandom);
        d_byte_en = 1'($urandom);
        d_addr    = 16'($urandom);
        d_wdata   = 16'($urandom);
      end
    end
    stuck     = (cyc % 400) >= 340;
    mem_ready = stuck ? 1'b0 : ($urandom_range(0, 9) < 4);
    mem_rdata = 16'($urandom);
  endtask

  initial begin
    reset = 0; if_req = 0; d_req = 0; d_we = 0; d_byte_en = 0; mem_ready = 0;
    if_addr = 0; d_addr = 0; d_wdata = 0; mem_rdata = 0;
    @(posedge clock);
    model_update();
    #1;
    chk("rst_mem_req",   mem_req,   1'b0);
    chk("rst_if_valid",  if_valid,  1'b0);
    chk("rst_d_valid",   d_valid,   1'b0);
    chk("rst_bus_error", bus_error, 1'b0);
    chk("rst_mem_addr",  mem_addr,  16'h0000);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      gen_inputs(cyc);
      #1;
      compare_all();
      @(posedge clock);
      model_update();
      #1;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
